uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver.
- Captures each byte the receiver presents with its one-cycle done pulse into a synchronous FIFO.
- Presents buffered bytes on a valid/ready stream to the host/bus side.
- Tracks overflow (sticky) and counts receiver framing errors for status registers.

---
 rtl/uart_rx_fifo_pkg.sv | 16 +
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_rx_fifo.sv | 114 +++++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults and helpers for the UART receive-side FIFO slice.
// Imported by uart_sync_fifo and uart_rx_fifo.
package uart_rx_fifo_pkg;

  localparam int DEFAULT_PAYLOAD_SIZE = 8;
  localparam int DEFAULT_DEPTH        = 16;
  localparam int ERR_COUNT_W          = 8;

  localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = '1;

  // Saturating increment for status counters
  function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] value);
    return (value == ERR_COUNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_PAYLOAD_SIZE,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_level
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;

  logic              w_empty;
  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  // A push into a full FIFO is legal only when the head leaves on the same edge
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && w_do_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FIFO capture of rx_done bytes, sticky overflow and framing-error counter.
// Optional UART_RX_FIFO_WATERMARK_EN adds WATERMARK and a registered almost_full for RTS.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int PAYLOAD_SIZE = DEFAULT_PAYLOAD_SIZE,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ADDR_W       = $clog2(DEPTH)
`ifdef UART_RX_FIFO_WATERMARK_EN
  ,
  parameter int WATERMARK    = DEPTH - 2
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PAYLOAD_SIZE-1:0]  rx_data,
  input  logic                     rx_done,
  input  logic                     rx_error,
  input  logic                     clear,
  output logic [PAYLOAD_SIZE-1:0]  m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ADDR_W:0]          level,
  output logic                     full,
  output logic                     overflow,
  output logic [ERR_COUNT_W-1:0]   err_count
`ifdef UART_RX_FIFO_WATERMARK_EN
  ,
  output logic                     almost_full
`endif
);

  logic                    w_empty;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_err_rise;

  logic                    r_overflow;
  logic                    r_rx_error_d;
  logic [ERR_COUNT_W-1:0]  r_err_count;

  assign w_pop  = ~w_empty & m_ready;
  assign w_push = rx_done & (~full | w_pop);
  // A byte flushed by clear is not an overflow
  assign w_drop = rx_done & full & ~w_pop & ~clear;

  uart_sync_fifo #(
    .WIDTH  (PAYLOAD_SIZE),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (clear),
    .i_push  (w_push),
    .i_wdata (rx_data),
    .i_pop   (w_pop),
    .o_rdata (m_data),
    .o_empty (w_empty),
    .o_full  (full),
    .o_level (level)
  );

  assign m_valid = ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign w_err_rise = rx_error & ~r_rx_error_d;

  // clear reloads the edge detector so a level already high is not counted again
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_error_d <= 1'b0;
      r_err_count  <= '0;
    end else if (clear) begin
      r_rx_error_d <= rx_error;
      r_err_count  <= '0;
    end else begin
      r_rx_error_d <= rx_error;
      if (w_err_rise) r_err_count <= sat_inc(r_err_count);
    end
  end

  assign overflow  = r_overflow;
  assign err_count = r_err_count;

`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0] WM_LEVEL = WATERMARK[ADDR_W:0];

  logic [ADDR_W:0] w_level_next;
  logic            r_almost_full;

  assign w_level_next = level + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};

  // Tracks the occupancy the FIFO will hold after this edge
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_next >= WM_LEVEL);
    end
  end

  assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queued expected bytes checked by a handshake monitor.
// Status outputs are checked directly against hand-computed values.
module tb_uart_rx_fifo;

  localparam int PS    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PS-1:0]  rx_data;
  logic           rx_done;
  logic           rx_error;
  logic           clear;
  logic [PS-1:0]  m_data;
  logic           m_valid;
  logic           m_ready;
  logic [AW:0]    level;
  logic           full;
  logic           overflow;
  logic [7:0]     err_count;
`ifdef UART_RX_FIFO_WATERMARK_EN
  logic           almost_full;
`endif

  int nChecks = 0;
  int nFails  = 0;
  logic [PS-1:0] expQ [$];

`ifdef UART_RX_FIFO_WATERMARK_EN
  uart_rx_fifo #(.PAYLOAD_SIZE(PS), .DEPTH(DEPTH), .WATERMARK(14)) dut (
`else
  uart_rx_fifo #(.PAYLOAD_SIZE(PS), .DEPTH(DEPTH)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_error  (rx_error),
    .clear     (clear),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .err_count (err_count)
`ifdef UART_RX_FIFO_WATERMARK_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every accepted word must match the oldest expected byte
  always @(negedge clk) begin
    if (rst_n && !clear && m_valid && m_ready) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFails++;
        $display("[TB] FAIL pop_unexpected: got %02h, expected no data", m_data);
      end else begin
        logic [PS-1:0] exp;
        exp = expQ.pop_front();
        if (m_data !== exp) begin
          nFails++;
          $display("[TB] FAIL pop_data: got %02h, expected %02h", m_data, exp);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [PS-1:0] data, input logic done, input logic ready,
                               input logic err, input logic clr);
    rx_data  = data;
    rx_done  = done;
    m_ready  = ready;
    rx_error = err;
    clear    = clr;
    @(posedge clk);
    #1;
    rx_done  = 1'b0;
    m_ready  = 1'b0;
    rx_error = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic pushByte(input logic [PS-1:0] data, input bit expectOut);
    if (expectOut) expQ.push_back(data);
    applyStimulus(data, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!m_valid) break;
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("drain_empty", {31'd0, m_valid}, 32'd0);
    checkOutput("drain_queue", expQ.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; rx_error = 1'b0; clear = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_level", level, 32'd0);
    checkOutput("reset_valid", m_valid, 32'd0);
    checkOutput("reset_full", full, 32'd0);
    checkOutput("reset_overflow", overflow, 32'd0);
    checkOutput("reset_err_count", err_count, 32'd0);
    checkOutput("reset_m_data", m_data, 32'd0);

    $display("[TB] single byte");
    pushByte(8'hA5, 1'b1);
    checkOutput("single_valid", m_valid, 32'd1);
    checkOutput("single_data", m_data, 32'hA5);
    checkOutput("single_level", level, 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("single_pop_valid", m_valid, 32'd0);
    checkOutput("single_pop_level", level, 32'd0);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 16; i++) pushByte(8'(i), 1'b1);
    checkOutput("fill_full", full, 32'd1);
    checkOutput("fill_level", level, 32'd16);
    checkOutput("fill_overflow", overflow, 32'd0);
    pushByte(8'hFF, 1'b0);
    checkOutput("ovf_flag", overflow, 32'd1);
    checkOutput("ovf_level", level, 32'd16);
    drain();
    checkOutput("ovf_sticky", overflow, 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_overflow", overflow, 32'd0);

    $display("[TB] push and pop while full");
    for (int i = 0; i < 16; i++) pushByte(8'h10 + 8'(i), 1'b1);
    expQ.push_back(8'h55);
    applyStimulus(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("fullpp_level", level, 32'd16);
    checkOutput("fullpp_full", full, 32'd1);
    checkOutput("fullpp_overflow", overflow, 32'd0);
    drain();

    $display("[TB] error counter");
    for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("err_hold_once", err_count, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("err_count_4", err_count, 32'd4);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("err_saturate", err_count, 32'd255);
    for (int i = 0; i < 17; i++) pushByte(8'h60 + 8'(i), 1'b0);
    checkOutput("pre_clear_overflow", overflow, 32'd1);
    applyStimulus(8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_err_count", err_count, 32'd0);
    checkOutput("clear_overflow2", overflow, 32'd0);
    checkOutput("clear_level", level, 32'd0);
    checkOutput("clear_valid", m_valid, 32'd0);
    applyStimulus(8'h78, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_wins_push", level, 32'd0);
    checkOutput("clear_wins_ovf", overflow, 32'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) pushByte(8'h80 + 8'(i), 1'b0);
    checkOutput("midrst_pre_level", level, 32'd3);
    rst_n = 1'b0;
    applyStimulus(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checkOutput("midrst_valid", m_valid, 32'd0);
    checkOutput("midrst_level", level, 32'd0);
    pushByte(8'h3C, 1'b1);
    pushByte(8'h4D, 1'b1);
    checkOutput("midrst_head", m_data, 32'h3C);
    drain();

`ifdef UART_RX_FIFO_WATERMARK_EN
    $display("[TB] watermark");
    for (int i = 0; i < 13; i++) pushByte(8'hC0 + 8'(i), 1'b1);
    checkOutput("wm_below", almost_full, 32'd0);
    pushByte(8'hCD, 1'b1);
    checkOutput("wm_rise", almost_full, 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("wm_level13", level, 32'd13);
    checkOutput("wm_fall", almost_full, 32'd0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
